// File: rtl/multicycle_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : multicycle_sequencer (+ multicycle_sequencer_pkg)
// Description : FETCH/DECODE/EXECUTE/MEM/WRITEBACK control sequencer for the
//               RV32I subset, with sticky HALT on illegal op or memory timeout.
//               Optional performance counters built when PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================

package multicycle_sequencer_pkg;
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       is_branch;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [2:0] encoding;
    } control_type;
endpackage

module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  control_type ctrl_in,
    input  logic        alu_zero,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output control_type ex_control,
    output logic        reg_write_en,
    output logic        mem_to_reg,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  err_code,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
);

    localparam logic [2:0] c_st_fetch   = 3'd0;
    localparam logic [2:0] c_st_decode  = 3'd1;
    localparam logic [2:0] c_st_execute = 3'd2;
    localparam logic [2:0] c_st_mem     = 3'd3;
    localparam logic [2:0] c_st_wb      = 3'd4;
    localparam logic [2:0] c_st_halt    = 3'd5;

    localparam logic [1:0] c_err_illegal = 2'b01;
    localparam logic [1:0] c_err_imem    = 2'b10;
    localparam logic [1:0] c_err_dmem    = 2'b11;

    // Timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT
    localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    control_type r_ex_control;
    logic [1:0]  r_err;
    logic [7:0]  r_wait;

    logic w_fetch, w_decode, w_exec, w_mem, w_wb, w_halt;
    logic w_fetch_done, w_mem_done, w_fetch_to, w_mem_to;
    logic w_illegal, w_is_mem_op, w_branch_exec, w_retire, w_wait_clr;

    assign w_fetch  = (r_state == c_st_fetch);
    assign w_decode = (r_state == c_st_decode);
    assign w_exec   = (r_state == c_st_execute);
    assign w_mem    = (r_state == c_st_mem);
    assign w_wb     = (r_state == c_st_wb);
    assign w_halt   = (r_state == c_st_halt);

    assign w_fetch_done  = w_fetch & imem_ready;
    assign w_mem_done    = w_mem & dmem_ready;
    assign w_fetch_to    = w_fetch & ~imem_ready & (r_wait == c_wait_last);
    assign w_mem_to      = w_mem & ~dmem_ready & (r_wait == c_wait_last);
    assign w_illegal     = ~(ctrl_in.reg_write | ctrl_in.mem_write | ctrl_in.is_branch);
    assign w_is_mem_op   = r_ex_control.mem_read | r_ex_control.mem_write;
    assign w_branch_exec = w_exec & r_ex_control.is_branch;
    assign w_retire      = w_branch_exec | (w_mem_done & r_ex_control.mem_write) | w_wb;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_fetch: begin
                if (imem_ready)
                    w_state_nxt = c_st_decode;
                else if (w_fetch_to)
                    w_state_nxt = c_st_halt;
            end
            c_st_decode:
                w_state_nxt = w_illegal ? c_st_halt : c_st_execute;
            c_st_execute: begin
                if (r_ex_control.is_branch)
                    w_state_nxt = c_st_fetch;
                else if (w_is_mem_op)
                    w_state_nxt = c_st_mem;
                else
                    w_state_nxt = c_st_wb;
            end
            c_st_mem: begin
                if (dmem_ready)
                    w_state_nxt = r_ex_control.mem_write ? c_st_fetch : c_st_wb;
                else if (w_mem_to)
                    w_state_nxt = c_st_halt;
            end
            c_st_wb:   w_state_nxt = c_st_fetch;
            c_st_halt: w_state_nxt = c_st_halt;
            default:   w_state_nxt = c_st_fetch;
        endcase
    end

    assign w_wait_clr = ((w_state_nxt == c_st_fetch) && !w_fetch) ||
                        ((w_state_nxt == c_st_mem) && !w_mem);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_fetch;
            r_ex_control <= '0;
            r_err        <= 2'b00;
            r_wait       <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_decode)
                r_ex_control <= ctrl_in;
            if (w_decode && w_illegal)
                r_err <= c_err_illegal;
            else if (w_fetch_to)
                r_err <= c_err_imem;
            else if (w_mem_to)
                r_err <= c_err_dmem;
            if (w_wait_clr)
                r_wait <= 8'd0;
            else if ((w_fetch & ~imem_ready) | (w_mem & ~dmem_ready))
                r_wait <= r_wait + 8'd1;
        end
    end

    assign imem_req     = ~reset & w_fetch;
    assign ir_write     = ~reset & w_fetch_done;
    assign pc_write     = ~reset & (w_fetch_done | (w_branch_exec & alu_zero));
    assign pc_src       = ~reset & w_branch_exec;
    assign dmem_req     = ~reset & w_mem;
    assign dmem_we      = ~reset & w_mem & r_ex_control.mem_write;
    assign reg_write_en = ~reset & w_wb;
    assign mem_to_reg   = ~reset & w_wb & r_ex_control.mem_to_reg;
    assign retire       = ~reset & w_retire;
    assign halted       = w_halt;
    assign ex_control   = r_ex_control;
    assign err_code     = r_err;

`ifdef PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= 32'd0;
            r_instret   <= 32'd0;
        end else begin
            if (!w_halt)
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire)
                r_instret <= r_instret + 32'd1;
        end
    end

    assign cycle_count   = r_cycle_cnt;
    assign instret_count = r_instret;
`else
    assign cycle_count   = 32'd0;
    assign instret_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : tb_multicycle_sequencer
// Description : Directed bench; per-instruction phase model expanded into a
//               per-cycle expectation queue, checked every cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    control_type ctrl_in = '0;
    logic        alu_zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
    logic        reg_write_en, mem_to_reg, retire, halted;
    control_type ex_control;
    logic [1:0]  err_code;
    logic [31:0] cycle_count, instret_count;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .alu_zero(alu_zero),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .ex_control(ex_control), .reg_write_en(reg_write_en), .mem_to_reg(mem_to_reg),
        .retire(retire), .halted(halted), .err_code(err_code),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    typedef struct {
        logic        rst, ir, dr, az, mark, force_ret;
        control_type ctrl;
        logic        e_imem_req, e_ir_write, e_pc_write, e_pc_src, e_dmem_req, e_dmem_we;
        logic        e_rwe, e_m2r, e_retire, e_halted;
        logic [1:0]  e_err;
        control_type e_ex;
    } cyc_t;

    cyc_t        q[$];
    cyc_t        cur;
    logic        cur_valid = 1'b0;
    control_type m_ex = '0;
    logic [1:0]  m_err = 2'b00;
    logic [31:0] m_cyc = 0, m_ret = 0;
    int          n_checks = 0, n_fail = 0;
    int          tcyc = 0, dreq_n = 0, halt_cyc = 0;
    int          ret_log[$];

    function automatic control_type mk(input logic rw, mr, mw, m2r, br, as,
                                       input logic [1:0] op, input logic [2:0] enc);
        control_type c;
        c.reg_write = rw; c.mem_read = mr; c.mem_write = mw; c.mem_to_reg = m2r;
        c.is_branch = br; c.alu_src = as; c.alu_op = op; c.encoding = enc;
        return c;
    endfunction

    control_type C_ADD, C_SUB, C_ADDI, C_LW, C_SW, C_BEQ;
    initial begin
        C_ADD  = mk(1, 0, 0, 0, 0, 0, 2'b10, 3'd0);
        C_SUB  = mk(1, 0, 0, 0, 0, 0, 2'b11, 3'd0);
        C_ADDI = mk(1, 0, 0, 0, 0, 1, 2'b10, 3'd1);
        C_LW   = mk(1, 1, 0, 1, 0, 1, 2'b00, 3'd1);
        C_SW   = mk(0, 0, 1, 0, 0, 1, 2'b00, 3'd2);
        C_BEQ  = mk(0, 0, 0, 0, 1, 0, 2'b01, 3'd3);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int log_at(input int i);
        return (i < ret_log.size()) ? ret_log[i] : 0;
    endfunction

    function automatic cyc_t blank(input control_type c);
        cyc_t e;
        e = '{default: '0};
        e.ctrl = c; e.e_ex = m_ex; e.e_err = m_err; e.e_halted = (m_err != 2'b00);
        return e;
    endfunction

    // Expand one instruction into its per-cycle phases from the phase rules
    task automatic add_instr(input control_type c, input int fw, input int dw, input logic az);
        cyc_t e;
        for (int i = 0; i < fw && i < T; i++) begin
            e = blank(c); e.dr = 1'b1; e.e_imem_req = 1'b1; q.push_back(e);
        end
        if (fw >= T) begin m_err = 2'b10; return; end
        e = blank(c); e.ir = 1'b1; e.e_imem_req = 1'b1; e.e_ir_write = 1'b1; e.e_pc_write = 1'b1;
        q.push_back(e);
        e = blank(c); q.push_back(e);
        m_ex = c;
        if (!(c.reg_write || c.mem_write || c.is_branch)) begin m_err = 2'b01; return; end
        e = blank(c); e.az = az;
        if (c.is_branch) begin
            e.e_retire = 1'b1; e.e_pc_write = az; e.e_pc_src = 1'b1; q.push_back(e);
            return;
        end
        q.push_back(e);
        if (c.mem_read || c.mem_write) begin
            for (int i = 0; i < dw && i < T; i++) begin
                e = blank(c); e.ir = 1'b1; e.e_dmem_req = 1'b1; e.e_dmem_we = c.mem_write;
                q.push_back(e);
            end
            if (dw >= T) begin m_err = 2'b11; return; end
            e = blank(c); e.dr = 1'b1; e.e_dmem_req = 1'b1; e.e_dmem_we = c.mem_write;
            e.e_retire = c.mem_write; q.push_back(e);
            if (c.mem_write) return;
        end
        e = blank(c); e.e_rwe = 1'b1; e.e_m2r = c.mem_to_reg; e.e_retire = 1'b1;
        q.push_back(e);
    endtask

    task automatic add_halt(input int n);
        cyc_t e;
        for (int i = 0; i < n; i++) begin
            e = blank('0); e.ir = 1'b1; e.dr = 1'b1; q.push_back(e);
        end
    endtask

    task automatic add_reset(input int n);
        cyc_t e;
        for (int i = 0; i < n; i++) begin
            e = blank('0); e.rst = 1'b1; e.ir = 1'b1; e.dr = 1'b1; q.push_back(e);
            m_err = 2'b00; m_ex = '0;
        end
    endtask

    task automatic set_flag(input int s, input bit frc);
        cyc_t e;
        e = q[s];
        if (frc) e.force_ret = 1'b1; else e.mark = 1'b1;
        q[s] = e;
    endtask

    task automatic play();
        cyc_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk); #1;
            reset = e.rst; imem_ready = e.ir; dmem_ready = e.dr;
            alu_zero = e.az; ctrl_in = e.ctrl;
            if (e.mark) begin
                tcyc = 1; ret_log.delete(); dreq_n = 0; halt_cyc = 0;
            end else tcyc++;
            cur = e; cur_valid = 1'b1;
`ifdef PERF_CNT_EN
            if (e.force_ret) begin
                force dut.r_instret = 32'hFFFF_FFFF;
                #1;
                release dut.r_instret;
            end
`endif
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            chk("imem_req", imem_req, cur.e_imem_req);
            chk("ir_write", ir_write, cur.e_ir_write);
            chk("pc_write", pc_write, cur.e_pc_write);
            if (cur.e_pc_write) chk("pc_src", pc_src, cur.e_pc_src);
            chk("dmem_req", dmem_req, cur.e_dmem_req);
            if (cur.e_dmem_req) chk("dmem_we", dmem_we, cur.e_dmem_we);
            chk("reg_write_en", reg_write_en, cur.e_rwe);
            if (cur.e_rwe) chk("mem_to_reg", mem_to_reg, cur.e_m2r);
            chk("retire", retire, cur.e_retire);
            chk("halted", halted, cur.e_halted);
            chk("err_code", err_code, cur.e_err);
            chk("ex_control", ex_control, cur.e_ex);
`ifdef PERF_CNT_EN
            if (cur.force_ret) m_ret = 32'hFFFF_FFFF;
            chk("cycle_count", cycle_count, m_cyc);
            chk("instret_count", instret_count, m_ret);
            if (cur.rst) begin
                m_cyc = 0; m_ret = 0;
            end else begin
                if (!cur.e_halted) m_cyc = m_cyc + 1;
                if (cur.e_retire) m_ret = m_ret + 1;
            end
`else
            chk("cycle_count", cycle_count, 0);
            chk("instret_count", instret_count, 0);
`endif
            if (retire) ret_log.push_back(tcyc);
            if (dmem_req) dreq_n++;
            if (halted && halt_cyc == 0) halt_cyc = tcyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        add_reset(2);
        play();
        chk("rst_err_code", err_code, 0);
        chk("rst_ex_control", ex_control, 0);
        chk("rst_halted", halted, 0);

        // ADD then taken BEQ, zero-wait
        add_instr(C_ADD, 0, 0, 1'b0);
        add_instr(C_BEQ, 0, 0, 1'b1);
        set_flag(0, 0);
        add_reset(1);
        play();
        chk("add_beq_retires", ret_log.size(), 2);
        chk("add_retire_cycle", log_at(0), 4);
        chk("beq_retire_cycle", log_at(1), 7);

        // LW with 3 dmem waits, then a mix including a not-taken BEQ
        add_instr(C_LW, 0, 3, 1'b0);
        add_instr(C_SUB, 0, 0, 1'b0);
        add_instr(C_ADDI, 2, 0, 1'b0);
        add_instr(C_BEQ, 0, 0, 1'b0);
        add_instr(C_SW, 0, 1, 1'b0);
        set_flag(0, 0);
        add_reset(1);
        play();
        chk("lw_retire_cycle", log_at(0), 8);
        chk("mix_dmem_req_cycles", dreq_n, 6);
        chk("mix_retires", ret_log.size(), 5);

        // Illegal instruction
        add_instr('0, 0, 0, 1'b0);
        add_halt(4);
        set_flag(0, 0);
        add_reset(2);
        play();
        chk("illegal_halt_cycle", halt_cyc, 3);

        // Fetch timeout, then ready on the last allowed wait cycle
        add_instr(C_ADD, 10, 0, 1'b0);
        add_halt(3);
        set_flag(0, 0);
        add_reset(2);
        play();
        chk("imem_to_halt_cycle", halt_cyc, 5);
        add_instr(C_ADD, T - 1, 0, 1'b0);
        set_flag(0, 0);
        add_reset(1);
        play();
        chk("imem_late_ready_retire", log_at(0), 7);
        chk("imem_late_no_halt", halt_cyc, 0);

        // Data-memory timeout on a store
        add_instr(C_SW, 0, 9, 1'b0);
        add_halt(2);
        add_reset(2);
        play();

        // Reset during the MEM phase of a store
        begin
            int s;
            s = q.size();
            add_instr(C_SW, 0, 3, 1'b0);
            while (q.size() > s + 4) void'(q.pop_back());
            set_flag(s, 0);
            add_reset(1);
            add_instr(C_ADD, 0, 0, 1'b0);
            add_reset(1);
            play();
            chk("abort_retires", ret_log.size(), 1);
            chk("abort_add_retire_cycle", log_at(0), 9);
        end

        // Instruction counter wrap
        add_instr(C_ADD, 0, 0, 1'b0);
        set_flag(0, 1);
        add_reset(1);
        play();
`ifdef PERF_CNT_EN
        chk("instret_wrap", instret_count, 0);
`else
        chk("counters_off", cycle_count | instret_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the single-issue RV32I core subset (ADD, SUB, ADDI, LW, SW, BEQ). It sits between the combinational instruction decoder and the shared datapath, and steps each instruction through the FETCH, DECODE, EXECUTE, MEM and WRITEBACK phases. It drives the instruction-memory and data-memory request/ready handshakes, the PC/IR write strobes and the register-file write strobe. Illegal instructions and memory timeouts stop the core in a sticky HALT state.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum number of wait cycles on either memory handshake before an error halt; range 1..255.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ctrl_in  in  control_type  decoded control from the decoder for the current IR contents.
- alu_zero  in  1  ALU zero flag, valid during EXECUTE.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid; sampled only while imem_req=1.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable; qualified by dmem_req.
- dmem_ready  in  1  data access complete; sampled only while dmem_req=1.
- ir_write  out  1  load IR and old_pc from the fetch bus and PC.
- pc_write  out  1  PC update strobe.
- pc_src  out  1  0 selects PC+4; 1 selects the branch target (old_pc + imm).
- ex_control  out  control_type  copy of ctrl_in latched in DECODE, held until the next DECODE; feeds alu_op, alu_src and encoding to the datapath.
- reg_write_en  out  1  register-file write strobe.
- mem_to_reg  out  1  writeback mux select, valid when reg_write_en=1.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped.
- err_code  out  2  00 none, 01 illegal instruction, 10 imem timeout, 11 dmem timeout.
- cycle_count  out  32  see Configuration.
- instret_count  out  32  see Configuration.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. The reset state is FETCH.
- Register outputs on reset: ex_control='0, err_code=00, counters=0. All strobes are decoded from the state and forced to 0 while reset=1.
- FETCH:
  - imem_req=1 until imem_ready is sampled at 1.
  - On that cycle assert ir_write=1 and pc_write=1 with pc_src=0, then go to DECODE.
- DECODE (1 cycle):
  - ex_control <= ctrl_in.
  - If ctrl_in has reg_write, mem_write and is_branch all 0, the instruction is illegal: err_code <= 01 and go to HALT.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - is_branch: if alu_zero=1, assert pc_write=1 with pc_src=1. Assert retire and go to FETCH.
  - mem_read or mem_write: go to MEM.
  - Otherwise: go to WRITEBACK.
- MEM:
  - dmem_req=1 and dmem_we=ex_control.mem_write, held until dmem_ready.
  - On ready, a store asserts retire and goes to FETCH; a load goes to WRITEBACK.
- WRITEBACK (1 cycle):
  - reg_write_en=1, mem_to_reg=ex_control.mem_to_reg, retire=1, then go to FETCH.
- Timeout:
  - An 8-bit wait counter clears on entry to FETCH or MEM and increments on each cycle with req=1 and ready=0.
  - When the count reaches MEM_TIMEOUT with ready still 0, set err_code to 10 (FETCH) or 11 (MEM) and go to HALT.
  - A ready arriving on that same cycle wins over the timeout.
- HALT:
  - All strobes are 0 and halted=1. HALT is left only through reset.
- Ready outside its request window (for example, dmem_ready while in FETCH) is ignored.
- Reset mid-operation: state returns to FETCH on the next edge. Any outstanding request is dropped and no retire is issued.

## Timing
Cycle counts below assume zero-wait memories (ready in the first request cycle).
- Latencies from FETCH entry to the next FETCH entry:
  - BEQ: 3 cycles.
  - ADD, SUB, ADDI: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Each wait cycle on either handshake adds exactly 1 cycle.
- All strobes are Moore outputs except the ready-qualified ones, which are combinational from ready within the current state: ir_write, pc_write in FETCH, and the retire/transition in MEM.
- retire is asserted for exactly one cycle per instruction.
- The first imem_req appears in the first cycle with reset=0.

## Configuration
- PERF_CNT_EN defined:
  - cycle_count increments every cycle with reset=0 and state!=HALT.
  - instret_count increments on each retire.
  - Both wrap from 0xFFFF_FFFF to 0 and clear on reset.
- PERF_CNT_EN undefined: both outputs are constant 0 and no counter flops are built.

## Test plan
- Zero-wait memories, ADD followed by BEQ with alu_zero=1 -> retire at cycles 4 and 7; pc_src=1 on the BEQ EXECUTE cycle.
- LW with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles; reg_write_en=1 with mem_to_reg=1 in the next cycle; instruction total of 8 cycles.
- ctrl_in all zero in DECODE -> halted=1 and err_code=01 on the following cycle; no further imem_req until reset.
- MEM_TIMEOUT=4, imem_ready held at 0 -> HALT with err_code=10 after 4 wait cycles. Variant: ready on the 4th cycle -> no halt.
- Reset asserted mid-MEM of an SW -> dmem_req=0 in the reset cycle and no retire; FETCH resumes with imem_req=1 in the first cycle after reset deasserts.
- PERF_CNT_EN with instret_count preloaded near wrap (force 0xFFFF_FFFF) and one retire -> instret_count=0; without the macro, both counters read 0 throughout.
